table_checker: RTL and testbench

TABLE_CHECKER -- requirements
Module: table_checker

---
 rtl/tables_pkg.sv | 20 ++
 rtl/table_buf.sv | 43 ++++
 rtl/table_checker.sv | 117 +++++++++++
 tb/tb_table_checker.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/tables_pkg.sv
// Shared types and sizing for the multiplication-table checker.
// Includes the FSM state encoding and the buffer index range helper.
package tables_pkg;

    localparam int N_ENTRIES_DEF = 10;
    localparam int DW_DEF        = 10;
    localparam int SUM_W         = 14;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // True when a 4-bit buffer index addresses a populated entry.
    function automatic logic idx_in_range(input logic [3:0] idx, input logic [3:0] n_entries);
        return (idx < n_entries);
    endfunction

endpackage

// File: rtl/table_buf.sv
// Entry storage for one captured table with a combinational read port.
// Reads outside the populated range return zero.
module table_buf
    import tables_pkg::*;
#(
    parameter int N_ENTRIES = N_ENTRIES_DEF,
    parameter int DW        = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [3:0]    wr_idx,
    input  logic [DW-1:0] wr_data,
    input  logic [3:0]    rd_idx,
    output logic [DW-1:0] rd_data
);

    localparam logic [3:0] N_IDX = 4'(N_ENTRIES);

    logic [DW-1:0] mem_r [16];

    // Entry registers, cleared only by the system reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we && idx_in_range(wr_idx, N_IDX)) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    // Read mux gated to the populated range.
    always_comb begin
        rd_data = '0;
        if (idx_in_range(rd_idx, N_IDX)) begin
            rd_data = mem_r[rd_idx];
        end else begin
            rd_data = '0;
        end
    end

endmodule

// File: rtl/table_checker.sv
// Captures a streamed multiplication table, checks each product against
// an accumulated expectation, and keeps a running sum of the entries.
module table_checker
    import tables_pkg::*;
#(
    parameter int N_ENTRIES = N_ENTRIES_DEF,
    parameter int DW        = DW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DW-1:0]    a,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    input  logic [3:0]       rd_addr,
    output logic [DW-1:0]    rd_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [3:0]       err_idx,
    output logic [SUM_W-1:0] sum
);

    localparam logic [3:0] LAST_IDX = 4'(N_ENTRIES - 1);

    state_t           state_r;
    logic [DW-1:0]    a_r;
    logic [DW-1:0]    exp_r;
    logic [3:0]       cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic [3:0]       err_idx_r;
    logic [SUM_W-1:0] sum_r;
    logic             accept_s;

    // Abort wins over everything, so a same-cycle entry is never stored.
    assign accept_s = (state_r == ST_CAPTURE) && in_valid && !abort;

    // Control FSM with registered status outputs and datapath state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            a_r       <= '0;
            exp_r     <= '0;
            cnt_r     <= 4'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            err_idx_r <= 4'd0;
            sum_r     <= '0;
        end else if (abort) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_r       <= a;
                        exp_r     <= a;
                        cnt_r     <= 4'd0;
                        err_r     <= 1'b0;
                        err_idx_r <= 4'd0;
                        sum_r     <= '0;
                        state_r   <= ST_CAPTURE;
                        busy_r    <= 1'b1;
                        done_r    <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (in_valid) begin
                        sum_r <= sum_r + SUM_W'(in_data);
                        // Expectation wraps at DW bits, matching truncated products.
                        exp_r <= exp_r + a_r;
                        cnt_r <= cnt_r + 4'd1;
                        if ((in_data != exp_r) && !err_r) begin
                            err_r     <= 1'b1;
                            err_idx_r <= cnt_r;
                        end
                        if (cnt_r == LAST_IDX) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    table_buf #(
        .N_ENTRIES (N_ENTRIES),
        .DW        (DW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .we      (accept_s),
        .wr_idx  (cnt_r),
        .wr_data (in_data),
        .rd_idx  (rd_addr),
        .rd_data (rd_data)
    );

    assign busy    = busy_r;
    assign done    = done_r;
    assign err     = err_r;
    assign err_idx = err_idx_r;
    assign sum     = sum_r;

endmodule

// File: tb/tb_table_checker.sv
// Directed bench for table_checker: a reference model built from the table
// rules (products a*k) is compared every cycle, plus hand-computed checkpoints.
module tb_table_checker;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  a;
    logic        abort;
    logic        in_valid;
    logic [9:0]  in_data;
    logic [3:0]  rd_addr;
    logic [9:0]  rd_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [3:0]  err_idx;
    logic [13:0] sum;

    int n_vec  = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    table_checker #(.N_ENTRIES(10), .DW(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .abort    (abort),
        .in_valid (in_valid),
        .in_data  (in_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_idx  (err_idx),
        .sum      (sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 capturing, 2 table complete.
    int          m_phase;
    int          m_cnt;
    logic [9:0]  m_a;
    logic [9:0]  m_buf [16];
    logic [13:0] m_sum;
    logic        m_err;
    logic [3:0]  m_err_idx;

    function automatic logic [9:0] product(input logic [9:0] op, input int k);
        int p;
        p = int'(op) * k;
        return p[9:0];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase   <= 0;
            m_cnt     <= 0;
            m_a       <= '0;
            m_sum     <= '0;
            m_err     <= 1'b0;
            m_err_idx <= '0;
            for (int i = 0; i < 16; i++) m_buf[i] <= '0;
        end else if (abort) begin
            m_phase <= 0;
        end else if (m_phase != 1 && start) begin
            m_phase   <= 1;
            m_a       <= a;
            m_cnt     <= 0;
            m_sum     <= '0;
            m_err     <= 1'b0;
            m_err_idx <= '0;
        end else if (m_phase == 1 && in_valid) begin
            m_buf[m_cnt] <= in_data;
            m_sum        <= m_sum + 14'(in_data);
            if (in_data != product(m_a, m_cnt + 1) && !m_err) begin
                m_err     <= 1'b1;
                m_err_idx <= 4'(m_cnt);
            end
            m_cnt <= m_cnt + 1;
            if (m_cnt == 9) m_phase <= 2;
        end
    end

    task automatic check(input string name, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", int'(busy), (m_phase == 1) ? 1 : 0);
            check("cyc_done", int'(done), (m_phase == 2) ? 1 : 0);
            check("cyc_err", int'(err), int'(m_err));
            check("cyc_err_idx", int'(err_idx), int'(m_err_idx));
            check("cyc_sum", int'(sum), int'(m_sum));
            check("cyc_rd_data", int'(rd_data), (rd_addr < 4'd10) ? int'(m_buf[rd_addr]) : 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic begin_table(input logic [9:0] op);
        start = 1'b1;
        a     = op;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [9:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; abort = 1'b0;
        in_valid = 1'b0; in_data = '0; rd_addr = '0;
        repeat (3) step();
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_sum", int'(sum), 0);
        check("reset_err", int'(err), 0);

        // a=2, clean table
        begin_table(10'd2);
        check("s1_busy", int'(busy), 1);
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) check("s1_done_before_last", int'(done), 0);
            send(10'(2 * k));
        end
        check("s1_done", int'(done), 1);
        check("s1_err", int'(err), 0);
        check("s1_sum", int'(sum), 110);
        rd_addr = 4'd9;  #1;
        check("s1_rd9", int'(rd_data), 20);
        rd_addr = 4'd12; #1;
        check("s1_rd12", int'(rd_data), 0);

        // a=3 with two corrupted entries; first one at index 3 wins
        begin_table(10'd3);
        for (int k = 1; k <= 10; k++) begin
            if (k == 4)      send(10'd13);
            else if (k == 7) send(10'd22);
            else             send(10'(3 * k));
        end
        check("s2_err", int'(err), 1);
        check("s2_err_idx", int'(err_idx), 3);
        check("s2_done", int'(done), 1);

        // a=200, products truncated to 10 bits
        begin_table(10'd200);
        for (int k = 1; k <= 10; k++) send(product(10'd200, k));
        check("s3_err", int'(err), 0);
        check("s3_sum", int'(sum), 5880);
        rd_addr = 4'd5; #1;
        check("s3_rd5", int'(rd_data), 176);

        // a=5 with valid gaps and a stray start mid-capture
        begin_table(10'd5);
        for (int k = 1; k <= 10; k++) begin
            for (int g = 0; g < (k % 4); g++) begin
                if (k == 3 && g == 0) begin
                    start = 1'b1;
                    a     = 10'd7;
                end
                step();
                start = 1'b0;
            end
            send(10'(5 * k));
        end
        check("s4_err", int'(err), 0);
        check("s4_sum", int'(sum), 275);
        check("s4_done", int'(done), 1);

        // abort after four entries, colliding with start and in_valid
        begin_table(10'd2);
        for (int k = 1; k <= 4; k++) send(10'(2 * k));
        abort = 1'b1; start = 1'b1; a = 10'd9; in_valid = 1'b1; in_data = 10'd10;
        step();
        abort = 1'b0; start = 1'b0; in_valid = 1'b0;
        check("s5_abort_busy", int'(busy), 0);
        check("s5_abort_done", int'(done), 0);
        check("s5_abort_sum", int'(sum), 20);
        send(10'd99);
        check("s5_idle_sum", int'(sum), 20);

        // reset in the middle of a capture
        begin_table(10'd2);
        in_valid = 1'b1; in_data = 10'd2;
        step();
        in_data = 10'd4;
        step();
        #1 rst = 1'b1;
        #1;
        check("s6_busy", int'(busy), 0);
        check("s6_done", int'(done), 0);
        check("s6_err", int'(err), 0);
        check("s6_err_idx", int'(err_idx), 0);
        check("s6_sum", int'(sum), 0);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            check("s6_rd_zero", int'(rd_data), 0);
        end
        step();
        rst = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        check("s6_after_busy", int'(busy), 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
